genius_sprite_ctrl: RTL

//  Clocked, parametrised sprite-flag controller between the Genius game core and the VGA renderer.

---
 rtl/genius_sprite_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/genius_sprite_ctrl.sv
// Sprite-flag controller between the Genius game core and the VGA renderer.
// Turns game events into a registered one-hot flag word with colour hold and blinking banners.
module genius_sprite_ctrl #(
    parameter int NUM_COLORS  = 4,
    parameter int COLOR_W     = 2,
    parameter int HOLD_CYCLES = 8,
    parameter int BLINK_HALF  = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  PWR_BTN,
    input  logic                  VGA_FLAG,
    input  logic [COLOR_W-1:0]    VGA_COLOR,
    input  logic                  VGA_LOSE,
    input  logic                  VGA_WIN,
    output logic [NUM_COLORS+2:0] SPRITES_FLAGS,
    output logic                  COLOR_DONE
);
    localparam int FW     = NUM_COLORS + 3;
    localparam int MAX_HB = (HOLD_CYCLES > BLINK_HALF) ? HOLD_CYCLES : BLINK_HALF;
    localparam int MAX_V  = (MAX_HB > 2) ? MAX_HB : 2;
    localparam int CW     = $clog2(MAX_V);
    localparam logic [COLOR_W:0] COLOR_LIMIT = (COLOR_W+1)'(NUM_COLORS);

    typedef enum logic [2:0] {IDLE, POWER_ON, COLOR, LOSE, WIN} state_t;

    state_t               state_reg, state_next;
    logic [COLOR_W-1:0]   color_reg, color_next;
    logic [CW-1:0]        hold_reg, hold_next;
    logic [CW-1:0]        blink_reg, blink_next;
    logic                 phase_reg, phase_next;
    logic [FW-1:0]        flags_reg, flags_next;
    logic                 done_reg, done_next;
    logic                 valid_req;
    logic [NUM_COLORS-1:0] color_onehot;

    // Out-of-range colour indices never count as a request.
    assign valid_req = VGA_FLAG && ({1'b0, VGA_COLOR} < COLOR_LIMIT);

    always_comb begin
        state_next = state_reg;
        color_next = color_reg;
        hold_next  = hold_reg;
        blink_next = blink_reg;
        phase_next = phase_reg;
        done_next  = 1'b0;

        case (state_reg)
            IDLE, POWER_ON: begin
                if (VGA_LOSE) begin
                    state_next = LOSE;
                    blink_next = '0;
                    phase_next = 1'b1;
                end else if (VGA_WIN) begin
                    state_next = WIN;
                    blink_next = '0;
                    phase_next = 1'b1;
                end else if (valid_req) begin
                    state_next = COLOR;
                    color_next = VGA_COLOR;
                    hold_next  = CW'(HOLD_CYCLES - 1);
                end else if (PWR_BTN) begin
                    state_next = POWER_ON;
                end
            end
            COLOR: begin
                if (VGA_LOSE) begin
                    state_next = LOSE;
                    blink_next = '0;
                    phase_next = 1'b1;
                    done_next  = 1'b1;
                end else if (VGA_WIN) begin
                    state_next = WIN;
                    blink_next = '0;
                    phase_next = 1'b1;
                    done_next  = 1'b1;
                end else if (hold_reg != '0) begin
                    hold_next = hold_reg - 1'b1;
                end else if (!VGA_FLAG) begin
                    state_next = POWER_ON;
                    done_next  = 1'b1;
                end else if (valid_req && (VGA_COLOR != color_reg)) begin
                    color_next = VGA_COLOR;
                    hold_next  = CW'(HOLD_CYCLES - 1);
                    done_next  = 1'b1;
                end
            end
            LOSE, WIN: begin
                if (VGA_LOSE && (state_reg == WIN)) begin
                    state_next = LOSE;
                    blink_next = '0;
                    phase_next = 1'b1;
                end else if ((state_reg == LOSE) ? !VGA_LOSE : !VGA_WIN) begin
                    state_next = IDLE;
                end else if (BLINK_HALF > 0) begin
                    if (blink_reg == CW'(BLINK_HALF - 1)) begin
                        blink_next = '0;
                        phase_next = ~phase_reg;
                    end else begin
                        blink_next = blink_reg + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    generate
        for (genvar gi = 0; gi < NUM_COLORS; gi++) begin : g_color_dec
            assign color_onehot[gi] = (color_next == COLOR_W'(gi));
        end
    endgenerate

    // Flags are derived from next-state so they move on the same edge as the state.
    always_comb begin
        flags_next = '0;
        case (state_next)
            POWER_ON: flags_next[0] = 1'b1;
            COLOR: begin
                flags_next[0]      = 1'b1;
                flags_next[FW-1:3] = color_onehot;
            end
            LOSE:    flags_next[2] = phase_next;
            WIN:     flags_next[1] = phase_next;
            default: flags_next = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg <= IDLE;
            color_reg <= '0;
            hold_reg  <= '0;
            blink_reg <= '0;
            phase_reg <= 1'b0;
            flags_reg <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            color_reg <= color_next;
            hold_reg  <= hold_next;
            blink_reg <= blink_next;
            phase_reg <= phase_next;
            flags_reg <= flags_next;
            done_reg  <= done_next;
        end
    end

    assign SPRITES_FLAGS = flags_reg;
    assign COLOR_DONE    = done_reg;

endmodule
